ivb_write_sched: RTL and testbench

Arbiter and sequencer in front of the PCIe input vector buffer (the 128→256-bit assembler). It takes 128-bit beat streams from `NREQ` requesters (DMA channels) and grants the assembler to one requester for a whole packet. It drives the assembler's `wen`/`wleft`/`wdata` with the two-beat-per-vector cadence and the mandatory idle gap. It also issues the end-of-packet flush and counts completed 256-bit vectors.

---
 rtl/ivb_pkg.sv | 17 +
 rtl/ivb_write_sched_if.sv | 26 ++
 rtl/rr_arbiter.sv | 22 ++
 rtl/ivb_write_sched.sv | 131 +++++++++++++
 tb/tb_ivb_write_sched.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ivb_pkg.sv
// Shared constants and FSM state type for the IVB write scheduler.
package ivb_pkg;

  localparam int unsigned VEC_W  = 256;
  localparam int unsigned BEAT_W = VEC_W / 2;

  // Non-zero data with wen low takes the assembler from VALID back to IDLE.
  localparam logic [BEAT_W-1:0] FLUSH_WORD = {{(BEAT_W - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StArb,
    StSecond,
    StGap,
    StFlush
  } state_e;

endpackage

// File: rtl/ivb_write_sched_if.sv
// Requester beat streams plus the assembler write/complete handshake.
interface ivb_write_sched_if #(
  parameter int unsigned NREQ = 2
);
  import ivb_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*BEAT_W-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic                   ivb_wen;
  logic                   ivb_wleft;
  logic [BEAT_W-1:0]      ivb_wdata;
  logic                   ivb_rvalid;

  modport master (
    input  req_valid, req_data, req_last, ivb_rvalid,
    output req_ready, ivb_wen, ivb_wleft, ivb_wdata
  );

  modport slave (
    output req_valid, req_data, req_last, ivb_rvalid,
    input  req_ready, ivb_wen, ivb_wleft, ivb_wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant of the first request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned  NREQ  = 2,
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o
);

  always_comb begin
    gnt_o = '0;
    // Scan from the farthest slot back towards ptr_i so the nearest request is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NREQ]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ivb_write_sched.sv
// Packet arbiter and two-beat write sequencer in front of the 128->256 vector assembler.
module ivb_write_sched
  import ivb_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  ivb_write_sched_if.master   bus,
  output logic [NREQ-1:0]     grant,
  output logic                busy,
  output logic [CNT_W-1:0]    vec_count,
  output logic                pkt_done
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic             pkt_done_q, pkt_done_d;

  logic              locked;
  logic [NREQ-1:0]   arb_req, arb_gnt, beat_sel;
  logic [BEAT_W-1:0] beat_data;
  logic              owner_valid, owner_last;
  logic [PTR_W-1:0]  owner_idx, next_ptr;

  // While a packet is open only its owner may compete.
  assign locked      = |grant_q;
  assign arb_req     = locked ? (bus.req_valid & grant_q) : bus.req_valid;
  assign owner_valid = |(bus.req_valid & grant_q);
  assign owner_last  = |(bus.req_last & grant_q);
  assign beat_sel    = (state_q == StArb) ? arb_gnt : grant_q;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_i (arb_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    beat_data = '0;
    owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (beat_sel[i]) beat_data = bus.req_data[i*BEAT_W +: BEAT_W];
      if (grant_q[i])  owner_idx = PTR_W'(i);
    end
  end

  assign next_ptr = (owner_idx == PTR_W'(NREQ - 1)) ? '0 : owner_idx + PTR_W'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    last_d        = last_q;
    pkt_done_d    = 1'b0;
    vec_count_d   = vec_count_q;
    bus.req_ready = '0;
    bus.ivb_wen   = 1'b0;
    bus.ivb_wleft = 1'b0;
    bus.ivb_wdata = '0;

    if (bus.ivb_rvalid && (vec_count_q != '1)) vec_count_d = vec_count_q + CNT_W'(1);

    case (state_q)
      StArb: begin
        if (|arb_req) begin
          bus.req_ready = arb_gnt;
          bus.ivb_wen   = 1'b1;
          bus.ivb_wleft = 1'b1;
          bus.ivb_wdata = beat_data;
          grant_d       = arb_gnt;
          if (!locked) vec_count_d = '0;
          state_d       = StSecond;
        end
      end
      StSecond: begin
        if (owner_valid) begin
          bus.req_ready = grant_q;
          bus.ivb_wen   = 1'b1;
          bus.ivb_wdata = beat_data;
          last_d        = owner_last;
          state_d       = StGap;
        end
      end
      StGap: begin
        state_d = last_q ? StFlush : StArb;
      end
      StFlush: begin
        bus.ivb_wdata = FLUSH_WORD;
        pkt_done_d    = 1'b1;
        rr_ptr_d      = next_ptr;
        grant_d       = '0;
        last_d        = 1'b0;
        state_d       = StArb;
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StArb;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      last_q      <= 1'b0;
      vec_count_q <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      last_q      <= last_d;
      vec_count_q <= vec_count_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = locked;
  assign vec_count = vec_count_q;
  assign pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_ivb_write_sched.sv
// Directed bench for ivb_write_sched with a behavioural assembler and queue-fed requesters.
module tb_ivb_write_sched;
  import ivb_pkg::*;

  localparam int unsigned NREQ = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ivb_write_sched_if #(.NREQ(NREQ)) bus ();
  ivb_write_sched_if #(.NREQ(NREQ)) bus_s ();

  logic [NREQ-1:0] grant, grant_s;
  logic            busy, busy_s, pkt_done, pkt_done_s;
  logic [15:0]     vec_count;
  logic [1:0]      vec_count_s;

  ivb_write_sched #(.NREQ(NREQ), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .grant     (grant),
    .busy      (busy),
    .vec_count (vec_count),
    .pkt_done  (pkt_done)
  );

  // Narrow-counter copy fed the same requester stimulus.
  ivb_write_sched #(.NREQ(NREQ), .CNT_W(2)) dut_s (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_s),
    .grant     (grant_s),
    .busy      (busy_s),
    .vec_count (vec_count_s),
    .pkt_done  (pkt_done_s)
  );

  assign bus_s.req_valid = bus.req_valid;
  assign bus_s.req_data  = bus.req_data;
  assign bus_s.req_last  = bus.req_last;

  // Assembler model: rvalid two cycles after the second beat, rdata = {first, second}.
  logic [1:0]        rv_pipe, rv_pipe_s;
  logic [BEAT_W-1:0] asm_hi;
  logic [VEC_W-1:0]  asm_rdata;

  always @(posedge clk) begin
    if (reset) begin
      rv_pipe   <= '0;
      rv_pipe_s <= '0;
    end else begin
      rv_pipe   <= {rv_pipe[0], bus.ivb_wen & ~bus.ivb_wleft};
      rv_pipe_s <= {rv_pipe_s[0], bus_s.ivb_wen & ~bus_s.ivb_wleft};
      if (bus.ivb_wen && bus.ivb_wleft)  asm_hi <= bus.ivb_wdata;
      if (bus.ivb_wen && !bus.ivb_wleft) asm_rdata <= {asm_hi, bus.ivb_wdata};
    end
  end

  assign bus.ivb_rvalid   = rv_pipe[1];
  assign bus_s.ivb_rvalid = rv_pipe_s[1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  logic [BEAT_W:0] q0[$];
  logic [BEAT_W:0] q1[$];
  logic [NREQ-1:0] acc;

  task automatic push(input int ch, input logic last, input logic [BEAT_W-1:0] d);
    if (ch == 0) q0.push_back({last, d});
    else         q1.push_back({last, d});
  endtask

  // One cycle: retire the beats accepted last cycle, present the queue heads, settle.
  task automatic step();
    @(negedge clk);
    if (acc[0]) q0.delete(0);
    if (acc[1]) q1.delete(0);
    bus.req_valid = {q1.size() != 0, q0.size() != 0};
    bus.req_data  = '0;
    bus.req_last  = '0;
    if (q0.size() != 0) begin
      bus.req_data[BEAT_W-1:0] = q0[0][BEAT_W-1:0];
      bus.req_last[0]          = q0[0][BEAT_W];
    end
    if (q1.size() != 0) begin
      bus.req_data[2*BEAT_W-1:BEAT_W] = q1[0][BEAT_W-1:0];
      bus.req_last[1]                 = q1[0][BEAT_W];
    end
    #1;
    acc = reset ? '0 : (bus.req_ready & bus.req_valid);
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    acc = '0;
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic              v;
    logic [BEAT_W-1:0] d;
    logic              l;
    logic [1:0]        rdy;
    logic              wen;
    logic              wleft;
    logic [BEAT_W-1:0] wdata;
    logic [1:0]        gnt;
    logic              done;
    logic [15:0]       vec;
  } row_t;

  row_t tbl [9];
  logic [BEAT_W-1:0] da, db, dc, dd, de, df, one;

  initial begin
    da  = {4{32'hAAAA_0A01}};
    db  = {4{32'hBBBB_0B02}};
    dc  = {4{32'hCCCC_0C03}};
    dd  = {4{32'hDDDD_0D04}};
    de  = {4{32'hEEEE_0E05}};
    df  = {4{32'hFFFF_0F06}};
    one = 128'h1;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    acc = '0;

    // Single packet on req0; last on beat A must be ignored.
    tbl[0] = '{1'b1, da, 1'b1, 2'b01, 1'b1, 1'b1, da,  2'b00, 1'b0, 16'd0};
    tbl[1] = '{1'b1, db, 1'b0, 2'b01, 1'b1, 1'b0, db,  2'b01, 1'b0, 16'd0};
    tbl[2] = '{1'b1, dc, 1'b0, 2'b00, 1'b0, 1'b0, '0,  2'b01, 1'b0, 16'd0};
    tbl[3] = '{1'b1, dc, 1'b0, 2'b01, 1'b1, 1'b1, dc,  2'b01, 1'b0, 16'd0};
    tbl[4] = '{1'b1, dd, 1'b1, 2'b01, 1'b1, 1'b0, dd,  2'b01, 1'b0, 16'd1};
    tbl[5] = '{1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0, '0,  2'b01, 1'b0, 16'd1};
    tbl[6] = '{1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0, one, 2'b01, 1'b0, 16'd1};
    tbl[7] = '{1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0, '0,  2'b00, 1'b1, 16'd2};
    tbl[8] = '{1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0, '0,  2'b00, 1'b0, 16'd2};

    do_reset();
    #1;
    chk("reset grant", grant, '0);
    chk("reset busy", busy, 1'b0);
    chk("reset vec_count", vec_count, '0);
    chk("reset pkt_done", pkt_done, 1'b0);
    chk("reset req_ready", bus.req_ready, '0);
    chk("reset wen", bus.ivb_wen, 1'b0);
    chk("reset wleft", bus.ivb_wleft, 1'b0);
    chk("reset wdata", bus.ivb_wdata, '0);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.req_valid = {1'b0, tbl[i].v};
      bus.req_data  = {{BEAT_W{1'b0}}, tbl[i].d};
      bus.req_last  = {1'b0, tbl[i].l};
      #1;
      chk($sformatf("tbl[%0d] req_ready", i), bus.req_ready, tbl[i].rdy);
      chk($sformatf("tbl[%0d] wen", i), bus.ivb_wen, tbl[i].wen);
      chk($sformatf("tbl[%0d] wleft", i), bus.ivb_wleft, tbl[i].wleft);
      chk($sformatf("tbl[%0d] wdata", i), bus.ivb_wdata, tbl[i].wdata);
      chk($sformatf("tbl[%0d] grant", i), grant, tbl[i].gnt);
      chk($sformatf("tbl[%0d] busy", i), busy, |tbl[i].gnt);
      chk($sformatf("tbl[%0d] pkt_done", i), pkt_done, tbl[i].done);
      chk($sformatf("tbl[%0d] vec_count", i), vec_count, tbl[i].vec);
    end
    chk("single rdata", asm_rdata, {dc, dd});

    // Contention: both valid from reset, one-vector packets; req0 gets a second one.
    do_reset();
    push(0, 1'b0, da); push(0, 1'b1, db); push(0, 1'b0, dc); push(0, 1'b1, dd);
    push(1, 1'b0, de); push(1, 1'b1, df);
    for (int c = 0; c < 13; c++) begin
      step();
      case (c)
        0: begin
          chk("cont c0 ready", bus.req_ready, 2'b01);
          chk("cont c0 wdata", bus.ivb_wdata, da);
        end
        1: chk("cont c1 grant", grant, 2'b01);
        2: chk("cont gap ready", bus.req_ready, 2'b00);
        3: chk("cont flush wdata", bus.ivb_wdata, one);
        4: begin
          chk("cont c4 ready", bus.req_ready, 2'b10);
          chk("cont c4 wdata", bus.ivb_wdata, de);
          chk("cont c4 pkt_done", pkt_done, 1'b1);
        end
        5: chk("cont c5 grant", grant, 2'b10);
        8: begin
          chk("cont c8 ready", bus.req_ready, 2'b01);
          chk("cont c8 wdata", bus.ivb_wdata, dc);
        end
        9: chk("cont c9 grant", grant, 2'b01);
        12: begin
          chk("cont c12 pkt_done", pkt_done, 1'b1);
          chk("cont c12 grant", grant, 2'b00);
        end
        default: ;
      endcase
    end

    // Lock: req1 raises valid during req0's three-vector packet.
    do_reset();
    push(0, 1'b0, da); push(0, 1'b0, db); push(0, 1'b0, dc);
    push(0, 1'b0, dd); push(0, 1'b0, de); push(0, 1'b1, df);
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 1) begin
        push(1, 1'b0, dd);
        push(1, 1'b1, dc);
      end
      if (c >= 2 && c <= 9) chk($sformatf("lock c%0d ready1", c), bus.req_ready[1], 1'b0);
      if (c == 9) begin
        chk("lock flush wdata", bus.ivb_wdata, one);
        chk("lock flush grant", grant, 2'b01);
      end
      if (c == 10) begin
        chk("lock c10 ready", bus.req_ready, 2'b10);
        chk("lock c10 wdata", bus.ivb_wdata, dd);
        chk("lock c10 wleft", bus.ivb_wleft, 1'b1);
        chk("lock c10 vec_count", vec_count, 16'd3);
        chk("lock c10 pkt_done", pkt_done, 1'b1);
      end
      if (c == 11) begin
        chk("lock c11 vec_count", vec_count, 16'd0);
        chk("lock c11 grant", grant, 2'b10);
      end
    end
    for (int c = 0; c < 5; c++) step();

    // Stall: five idle cycles between the two beats of a vector.
    do_reset();
    push(0, 1'b0, de);
    step();
    chk("stall beat0 wen", bus.ivb_wen, 1'b1);
    chk("stall beat0 wleft", bus.ivb_wleft, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("stall c%0d wen", c), bus.ivb_wen, 1'b0);
      chk($sformatf("stall c%0d wdata", c), bus.ivb_wdata, '0);
    end
    push(0, 1'b1, df);
    step();
    chk("stall beat1 wen", bus.ivb_wen, 1'b1);
    chk("stall beat1 wleft", bus.ivb_wleft, 1'b0);
    chk("stall beat1 wdata", bus.ivb_wdata, df);
    step();
    step();
    step();
    chk("stall rdata", asm_rdata, {de, df});
    chk("stall vec_count", vec_count, 16'd1);
    chk("stall pkt_done", pkt_done, 1'b1);

    // Reset one cycle after beat0, then a clean packet.
    do_reset();
    push(0, 1'b0, da);
    push(0, 1'b1, db);
    step();
    q0.delete();
    acc = '0;
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    #1;
    chk("rst mid grant", grant, 2'b01);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst after grant", grant, 2'b00);
    chk("rst after busy", busy, 1'b0);
    chk("rst after wen", bus.ivb_wen, 1'b0);
    chk("rst after wdata", bus.ivb_wdata, '0);
    chk("rst after vec_count", vec_count, '0);
    step();
    chk("rst no flush done", pkt_done, 1'b0);
    chk("rst no flush wdata", bus.ivb_wdata, '0);
    push(0, 1'b0, dc);
    push(0, 1'b1, dd);
    for (int c = 0; c < 5; c++) step();
    chk("rst pkt rdata", asm_rdata, {dc, dd});
    chk("rst pkt vec_count", vec_count, 16'd1);
    chk("rst pkt done", pkt_done, 1'b1);

    // Saturation: five vectors into a 2-bit counter.
    do_reset();
    for (int v = 0; v < 5; v++) begin
      push(0, 1'b0, da ^ BEAT_W'(v));
      push(0, v == 4, db ^ BEAT_W'(v));
    end
    for (int c = 0; c < 17; c++) begin
      step();
      if (c == 10) chk("sat c10 vec_s", vec_count_s, 2'd3);
      if (c == 13) begin
        chk("sat c13 vec_s", vec_count_s, 2'd3);
        chk("sat c13 vec", vec_count, 16'd4);
      end
      if (c == 16) begin
        chk("sat c16 vec_s", vec_count_s, 2'd3);
        chk("sat c16 vec", vec_count, 16'd5);
        chk("sat c16 done_s", pkt_done_s, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
